// File: rtl/bsg_manycore_mem_responder_pkg.sv
// bsg_manycore_mem_responder_pkg: shared enums and packet struct macros for the scratchpad responder.
`define BSG_MANYCORE_MEM_RESPONDER_REQ_S(aw, dw, xw, yw) \
  struct packed { \
    logic [1:0] op; \
    logic [aw-1:0] addr; \
    logic [dw-1:0] data; \
    logic [(dw/8)-1:0] mask; \
    logic [4:0] reg_id; \
    logic [xw-1:0] src_x; \
    logic [yw-1:0] src_y; \
  }

`define BSG_MANYCORE_MEM_RESPONDER_RSP_S(xw, yw) \
  struct packed { \
    rsp_type_e rsp_type; \
    logic [4:0] reg_id; \
    logic [xw-1:0] dst_x; \
    logic [yw-1:0] dst_y; \
  }

package bsg_manycore_mem_responder_pkg;
  typedef enum logic [1:0] {e_load = 2'd0, e_store = 2'd1} op_e;
  typedef enum logic [1:0] {e_rsp_credit = 2'd0, e_rsp_int_wb = 2'd1, e_rsp_error = 2'd2} rsp_type_e;
  typedef enum logic [1:0] {e_idle, e_access, e_resp} state_e;
endpackage

// File: rtl/bsg_manycore_mem_responder_fifo.sv
// bsg_manycore_mem_responder_fifo: two-entry valid/ready FIFO with active-low async reset.
module bsg_manycore_mem_responder_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o
);
  logic [width_p-1:0] mem [2];
  logic wp, rp;
  logic [1:0] cnt;
  logic enq, deq;
  assign ready_o = cnt != 2'd2;
  assign v_o = cnt != 2'd0;
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;
  assign data_o = mem[rp];
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      wp <= wp ^ enq;
      rp <= rp ^ deq;
      cnt <= cnt + 2'(enq) - 2'(deq);
    end
  always_ff @(posedge clk_i)
    if (enq) mem[wp] <= data_i;
endmodule

// File: rtl/bsg_manycore_mem_responder_ram.sv
// bsg_manycore_mem_responder_ram: 1rw synchronous scratchpad with byte-masked writes.
module bsg_manycore_mem_responder_ram #(
  parameter int width_p = 32,
  parameter int els_p = 1024,
  parameter int addr_width_p = 10
) (
  input  logic                    clk_i,
  input  logic                    v_i,
  input  logic                    w_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [width_p-1:0]      data_i,
  input  logic [width_p/8-1:0]    mask_i,
  output logic [width_p-1:0]      data_o
);
  logic [width_p-1:0] mem [els_p];
  always_ff @(posedge clk_i)
    if (v_i) begin
      if (w_i) begin
        for (int b = 0; b < width_p/8; b++)
          if (mask_i[b]) mem[addr_i][8*b+:8] <= data_i[8*b+:8];
      end else data_o <= mem[addr_i];
    end
endmodule

// File: rtl/bsg_manycore_mem_responder.sv
// bsg_manycore_mem_responder: answers manycore loads/stores against a local scratchpad,
// serialising requests through a FIFO and an IDLE/ACCESS/RESP FSM.
module bsg_manycore_mem_responder
  import bsg_manycore_mem_responder_pkg::*;
#(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int els_p = 1024,
  parameter int base_addr_p = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      req_v_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [data_width_p-1:0]   req_data_i,
  input  logic [data_width_p/8-1:0] req_mask_i,
  input  logic [4:0]                req_reg_id_i,
  input  logic [x_cord_width_p-1:0] req_src_x_i,
  input  logic [y_cord_width_p-1:0] req_src_y_i,
  output logic                      rsp_v_o,
  input  logic                      rsp_ready_i,
  output logic [1:0]                rsp_type_o,
  output logic [data_width_p-1:0]   rsp_data_o,
  output logic [4:0]                rsp_reg_id_o,
  output logic [x_cord_width_p-1:0] rsp_dst_x_o,
  output logic [y_cord_width_p-1:0] rsp_dst_y_o,
  output logic                      busy_o
);
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [addr_width_p:0] base_lp = (addr_width_p+1)'(base_addr_p);
  localparam logic [addr_width_p:0] els_lp = (addr_width_p+1)'(els_p);
  typedef `BSG_MANYCORE_MEM_RESPONDER_REQ_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p) req_s;
  typedef `BSG_MANYCORE_MEM_RESPONDER_RSP_S(x_cord_width_p, y_cord_width_p) rsp_s;
  req_s fifo_in, fifo_out, req_r;
  rsp_s rsp_r, rsp_n;
  state_e state;
  logic fifo_v, rsp_v, ok, ram_v;
  logic [addr_width_p:0] offset;
  logic [data_width_p-1:0] ram_q;
  assign fifo_in = '{op: req_op_i, addr: req_addr_i, data: req_data_i, mask: req_mask_i,
                     reg_id: req_reg_id_i, src_x: req_src_x_i, src_y: req_src_y_i};
  bsg_manycore_mem_responder_fifo #(.width_p($bits(req_s))) fifo (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .v_i(req_v_i),
    .ready_o(req_ready_o),
    .data_i(fifo_in),
    .v_o(fifo_v),
    .yumi_i(state == e_idle),
    .data_o(fifo_out)
  );
  // An address below the base wraps to >= 2^addr_width_p in the extended width, so one compare covers both bounds.
  assign offset = {1'b0, req_r.addr} - base_lp;
  assign ok = (offset < els_lp) && (req_r.op == e_load || req_r.op == e_store);
  assign ram_v = (state == e_access) && ok;
  assign rsp_n = '{rsp_type: !ok ? e_rsp_error : (req_r.op == e_store ? e_rsp_credit : e_rsp_int_wb),
                   reg_id: req_r.reg_id, dst_x: req_r.src_x, dst_y: req_r.src_y};
  bsg_manycore_mem_responder_ram #(.width_p(data_width_p), .els_p(els_p), .addr_width_p(lg_els_lp)) ram (
    .clk_i(clk_i),
    .v_i(ram_v),
    .w_i(req_r.op == e_store),
    .addr_i(offset[lg_els_lp-1:0]),
    .data_i(req_r.data),
    .mask_i(req_r.mask),
    .data_o(ram_q)
  );
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= e_idle;
      req_r <= '0;
      rsp_r <= '0;
      rsp_v <= 1'b0;
    end else
      case (state)
        e_idle: if (fifo_v) begin
          req_r <= fifo_out;
          state <= e_access;
        end
        e_access: begin
          rsp_r <= rsp_n;
          rsp_v <= 1'b1;
          state <= e_resp;
        end
        e_resp: if (rsp_ready_i) begin
          rsp_v <= 1'b0;
          state <= e_idle;
        end
        default: state <= e_idle;
      endcase
  // The RAM is idle outside ACCESS, so its output register holds the load data stable through RESP.
  assign rsp_data_o = (rsp_r.rsp_type == e_rsp_int_wb) ? ram_q : '0;
  assign rsp_v_o = rsp_v;
  assign rsp_type_o = rsp_r.rsp_type;
  assign rsp_reg_id_o = rsp_r.reg_id;
  assign rsp_dst_x_o = rsp_r.dst_x;
  assign rsp_dst_y_o = rsp_r.dst_y;
  assign busy_o = fifo_v || state != e_idle;
endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// tb_bsg_manycore_mem_responder: directed and randomized checks of the responder against a queue-based model.
module tb_bsg_manycore_mem_responder;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  logic req_v = 0, req_ready, rsp_v, rsp_ready = 0, busy;
  logic [1:0] req_op = 0, rsp_type;
  logic [27:0] req_addr = 0;
  logic [31:0] req_data = 0, rsp_data;
  logic [3:0] req_mask = 0;
  logic [4:0] req_reg_id = 0, rsp_reg_id;
  logic [6:0] req_src_x = 0, req_src_y = 0, rsp_dst_x, rsp_dst_y;

  bsg_manycore_mem_responder dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .req_ready_o(req_ready), .req_op_i(req_op), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_mask_i(req_mask), .req_reg_id_i(req_reg_id),
    .req_src_x_i(req_src_x), .req_src_y_i(req_src_y),
    .rsp_v_o(rsp_v), .rsp_ready_i(rsp_ready), .rsp_type_o(rsp_type), .rsp_data_o(rsp_data),
    .rsp_reg_id_o(rsp_reg_id), .rsp_dst_x_o(rsp_dst_x), .rsp_dst_y_o(rsp_dst_y), .busy_o(busy)
  );

  typedef struct {logic [1:0] ty; logic [31:0] d; logic [4:0] tag; logic [6:0] x; logic [6:0] y;} exp_t;
  exp_t exp_q[$];
  logic [31:0] mem_m [1024];
  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Requests are served strictly in order, so the response can be computed when the request is accepted.
  function automatic exp_t model(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                                 input logic [3:0] mask, input logic [4:0] tag, input logic [6:0] x, input logic [6:0] y);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y; e.d = 0;
    if (op > 1 || addr >= 1024) e.ty = 2;
    else if (op == 1) begin
      for (int b = 0; b < 4; b++) if (mask[b]) mem_m[addr[9:0]][8*b+:8] = data[8*b+:8];
      e.ty = 0;
    end else begin
      e.ty = 1;
      e.d = mem_m[addr[9:0]];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) exp_q.delete();
    else begin
      if (rsp_v) begin
        if (exp_q.size() == 0) check("rsp_v_without_request", rsp_v, 1'b0);
        else begin
          check("rsp_type", rsp_type, exp_q[0].ty);
          check("rsp_data", rsp_data, exp_q[0].d);
          check("rsp_reg_id", rsp_reg_id, exp_q[0].tag);
          check("rsp_dst_x", rsp_dst_x, exp_q[0].x);
          check("rsp_dst_y", rsp_dst_y, exp_q[0].y);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (req_v && req_ready)
        exp_q.push_back(model(req_op, req_addr, req_data, req_mask, req_reg_id, req_src_x, req_src_y));
    end
  end

  task automatic set_req(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [4:0] tag, input logic [6:0] x, input logic [6:0] y);
    req_op = op; req_addr = addr; req_data = data; req_mask = mask;
    req_reg_id = tag; req_src_x = x; req_src_y = y;
  endtask

  task automatic send(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [4:0] tag, input logic [6:0] x, input logic [6:0] y);
    int t = 0;
    set_req(op, addr, data, mask, tag, x, y);
    req_v = 1;
    @(negedge clk);
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    check("req_accept_timeout", req_ready, 1);
    @(posedge clk); #1 req_v = 0;
  endtask

  task automatic recv(output logic [1:0] ty, output logic [31:0] d, output logic [4:0] tag,
                      output logic [6:0] x, output logic [6:0] y, output int lat);
    int k = 0;
    rsp_ready = 1;
    do begin @(negedge clk); k++; end while (!rsp_v && k < 100);
    check("rsp_timeout", rsp_v, 1);
    ty = rsp_type; d = rsp_data; tag = rsp_reg_id; x = rsp_dst_x; y = rsp_dst_y; lat = k - 1;
    @(posedge clk); #1 rsp_ready = 0;
  endtask

  task automatic drain();
    int t = 0;
    rsp_ready = 1;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && t < 300) begin @(negedge clk); t++; end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_req();
    int r = $urandom % 8;
    int o = $urandom % 8;
    logic [27:0] a;
    a = r < 3 ? 28'($urandom % 16) : r < 6 ? 28'(1008 + $urandom % 16) :
        r == 6 ? 28'(1024 + $urandom % 64) : (28'($urandom) | 28'h400);
    set_req(o < 3 ? 2'd0 : o < 7 ? 2'd1 : 2'(2 + $urandom % 2), a, $urandom, 4'($urandom),
            5'($urandom), 7'($urandom), 7'($urandom));
  endtask

  logic [1:0] ty;
  logic [31:0] d;
  logic [4:0] tag;
  logic [6:0] x, y;
  int lat, acc;
  logic rdy [4];

  initial begin
    #2;
    check("reset_rsp_v", rsp_v, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_type", rsp_type, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_reg_id", rsp_reg_id, 0);
    check("reset_rsp_dst", {rsp_dst_x, rsp_dst_y}, 0);
    #20 reset_n = 1;
    @(posedge clk); #1;
    check("post_reset_ready", req_ready, 1);
    check("post_reset_busy", busy, 0);
    for (int i = 0; i < 32; i++) begin
      send(1, i < 16 ? 28'(i) : 28'(992 + i), $urandom, 4'hF, 5'(i), 1, 1);
      recv(ty, d, tag, x, y, lat);
    end
    send(1, 5, 32'hDEADBEEF, 4'hF, 3, 2, 9);
    recv(ty, d, tag, x, y, lat);
    check("store_type", ty, 0);
    check("store_data", d, 0);
    check("store_tag", tag, 3);
    check("store_dst", {x, y}, {7'd2, 7'd9});
    send(0, 5, 0, 0, 4, 2, 9);
    recv(ty, d, tag, x, y, lat);
    check("load_type", ty, 1);
    check("load_data", d, 32'hDEADBEEF);
    check("load_latency", lat, 2);
    send(1, 5, 32'h000000AA, 4'h1, 5, 3, 4);
    recv(ty, d, tag, x, y, lat);
    send(0, 5, 0, 0, 6, 3, 4);
    recv(ty, d, tag, x, y, lat);
    check("masked_load_data", d, 32'hDEADBEAA);
    send(1, 5, 32'h12345678, 4'h0, 7, 3, 4);
    recv(ty, d, tag, x, y, lat);
    check("mask0_store_type", ty, 0);
    send(0, 5, 0, 0, 8, 3, 4);
    recv(ty, d, tag, x, y, lat);
    check("mask0_load_data", d, 32'hDEADBEAA);
    send(0, 1024, 0, 0, 9, 1, 2);
    recv(ty, d, tag, x, y, lat);
    check("oor_type", ty, 2);
    check("oor_data", d, 0);
    send(3, 0, 32'hFFFFFFFF, 4'hF, 10, 1, 2);
    recv(ty, d, tag, x, y, lat);
    check("illegal_op_type", ty, 2);
    check("illegal_op_data", d, 0);
    send(0, 0, 0, 0, 11, 1, 2);
    recv(ty, d, tag, x, y, lat);
    check("illegal_no_write", d, mem_m[0]);
    // reset while a response is stalled in RESP
    rsp_ready = 0;
    send(0, 5, 0, 0, 12, 5, 5);
    acc = 0;
    @(negedge clk);
    while (!rsp_v && acc < 20) begin @(negedge clk); acc++; end
    check("pre_reset_rsp_v", rsp_v, 1);
    @(posedge clk); #3 reset_n = 0;
    #1;
    check("async_rsp_v", rsp_v, 0);
    check("async_busy", busy, 0);
    check("async_rsp_type", rsp_type, 0);
    @(negedge clk); @(negedge clk); #2 reset_n = 1;
    @(posedge clk); #1;
    check("rerelease_ready", req_ready, 1);
    check("rerelease_busy", busy, 0);
    send(0, 5, 0, 0, 13, 5, 5);
    recv(ty, d, tag, x, y, lat);
    check("post_reset_load", d, 32'hDEADBEAA);
    // backpressure: 4 back-to-back stores with the response path stalled
    rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_req(1, 28'(8 + i), 32'hA0A0_0000 + i, 4'hF, 5'(20 + i), 7'(i), 7'(i));
      req_v = 1;
      @(negedge clk); rdy[i] = req_ready;
      @(posedge clk); #1;
    end
    acc = 0;
    for (int i = 0; i < 4; i++) acc += int'(rdy[i]);
    check("bp_accepted", acc, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("bp_ready_low", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    acc = 0;
    @(negedge clk);
    while (!req_ready && acc < 20) begin @(negedge clk); acc++; end
    check("bp_4th_accept", req_ready, 1);
    @(posedge clk); #1 req_v = 0;
    drain();
    for (int i = 0; i < 4; i++) begin
      send(0, 28'(8 + i), 0, 0, 5'(i), 0, 0);
      recv(ty, d, tag, x, y, lat);
      check("bp_store_data", d, 32'hA0A0_0000 + i);
    end
    // randomized traffic with random response backpressure
    begin
      int sent = 0, c = 0;
      logic a;
      req_v = 0;
      while (c < 6000 && !(sent >= 400 && !req_v)) begin
        @(negedge clk); a = req_v && req_ready;
        @(posedge clk); #1;
        if (a || !req_v) begin
          if (sent < 400 && $urandom % 4 != 0) begin rand_req(); req_v = 1; sent++; end
          else req_v = 0;
        end
        rsp_ready = ($urandom % 3 != 0);
        c++;
      end
      check("random_phase_done", req_v, 0);
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
